// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions: opcode encodings, default field widths and the
// loadable instruction memory FSM encoding.
package cpu_isa_pkg;

   localparam int OPC_W_DEF   = 5;
   localparam int INSTR_W_DEF = 9;

   localparam logic [4:0] OPC_ADD         = 5'b00000;
   localparam logic [4:0] OPC_SUB         = 5'b00001;
   localparam logic [4:0] OPC_AND         = 5'b00010;
   localparam logic [4:0] OPC_OR          = 5'b00011;
   localparam logic [4:0] OPC_XOR         = 5'b00100;
   localparam logic [4:0] OPC_NOT         = 5'b00101;
   localparam logic [4:0] OPC_SETI        = 5'b00110;
   localparam logic [4:0] OPC_MOV         = 5'b00111;
   localparam logic [4:0] OPC_LOAD        = 5'b01000;
   localparam logic [4:0] OPC_STORE       = 5'b01001;
   localparam logic [4:0] OPC_JMP         = 5'b01010;
   localparam logic [4:0] OPC_JZ          = 5'b01011;
   localparam logic [4:0] OPC_JNZ         = 5'b01100;
   localparam logic [4:0] OPC_CMP         = 5'b01101;
   localparam logic [4:0] OPC_SHL         = 5'b01110;
   localparam logic [4:0] OPC_SHR         = 5'b01111;
   localparam logic [4:0] OPC_INC         = 5'b10000;
   localparam logic [4:0] OPC_DEC         = 5'b10001;
   localparam logic [4:0] OPC_MATHTOADR   = 5'b10010;
   localparam logic [4:0] OPC_ADRTOMATH   = 5'b10011;
   localparam logic [4:0] OPC_PUSH        = 5'b10100;
   localparam logic [4:0] OPC_POP         = 5'b10101;
   localparam logic [4:0] OPC_CALL        = 5'b10110;
   localparam logic [4:0] OPC_RET         = 5'b10111;
   localparam logic [4:0] OPC_IN          = 5'b11000;
   localparam logic [4:0] OPC_OUT         = 5'b11001;
   localparam logic [4:0] OPC_HALT        = 5'b11010;
   localparam logic [4:0] OPC_TOBEDEFINED = 5'b11011;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } imem_state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x W synchronous RAM: one write port, one registered read port, plus a
// per-word loaded flag that can be cleared in a single cycle.
module instr_mem_array
   import cpu_isa_pkg::*;
#(
   parameter int W     = INSTR_W_DEF,
   parameter int DEPTH = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_clr,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata,
   output logic          o_loaded
);

   logic [W-1:0]     r_mem [DEPTH];
   logic [DEPTH-1:0] r_loaded;
   logic [W-1:0]     r_rdata;
   logic             w_raddr_ok;

   // Guards non-power-of-two depths where the index can exceed the array.
   assign w_raddr_ok = ({1'b0, i_raddr} < (AW+1)'(DEPTH));

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= w_raddr_ok ? r_mem[i_raddr] : '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_loaded <= '0;
      end else if (i_clr) begin
         r_loaded <= '0;
      end else if (i_we) begin
         r_loaded[i_waddr] <= 1'b1;
      end
   end

   assign o_rdata  = r_rdata;
   assign o_loaded = w_raddr_ok && r_loaded[i_raddr];

endmodule

// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: host streams a program in through a
// ready/valid port, the fetch stage reads it with one-cycle latency and stall.
module instr_mem_loadable
   import cpu_isa_pkg::*;
#(
   parameter int               INSTR_W  = INSTR_W_DEF,
   parameter int               OPC_W    = OPC_W_DEF,
   parameter int               ADDR_W   = 16,
   parameter int               DEPTH    = 64,
   parameter int               BASE_PC  = 1,
   parameter logic [OPC_W-1:0] HALT_OPC = OPC_HALT
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_load_start,
   input  logic               i_load_valid,
   input  logic               i_load_last,
   input  logic [INSTR_W-1:0] i_load_data,
   output logic               o_load_ready,
   input  logic               i_fetch_req,
   input  logic [ADDR_W-1:0]  i_fetch_pc,
   input  logic               i_stall,
   output logic               o_instr_valid,
   output logic [INSTR_W-1:0] o_instr,
   output logic [ADDR_W-1:0]  o_pc_out,
   output logic               o_fault,
   output logic               o_halted,
   output logic               o_ready
);

   localparam int AW = $clog2(DEPTH);

   imem_state_e        r_state, w_state_nxt;
   logic [AW-1:0]      r_wptr;
   logic               r_instr_valid, r_fault, r_halted;
   logic [ADDR_W-1:0]  r_pc;

   logic               w_load_acc, w_load_end;
   logic               w_fetch_acc, w_in_range, w_loaded_bit, w_hit, w_halt_now;
   logic [ADDR_W-1:0]  w_idx;
   logic [INSTR_W-1:0] w_rdata;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      o_load_ready = 1'b0;
      o_ready      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_load_start) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            o_load_ready = 1'b1;
            if (i_load_start)                  w_state_nxt = ST_LOAD;
            else if (w_load_acc && w_load_end) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            o_ready = 1'b1;
            if (i_load_start) w_state_nxt = ST_LOAD;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // A restart pulse discards any word offered in the same cycle.
   assign w_load_acc = o_load_ready && i_load_valid && !i_load_start;
   assign w_load_end = i_load_last || (r_wptr == AW'(DEPTH-1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
      end else if (i_load_start) begin
         r_wptr <= '0;
      end else if (w_load_acc) begin
         r_wptr <= w_load_end ? '0 : r_wptr + AW'(1);
      end
   end

   assign w_idx      = i_fetch_pc - ADDR_W'(BASE_PC);
   assign w_in_range = (i_fetch_pc >= ADDR_W'(BASE_PC)) && (w_idx < ADDR_W'(DEPTH));
   assign w_hit      = w_in_range && w_loaded_bit;

   instr_mem_array #(
      .W     (INSTR_W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_clr    (i_load_start),
      .i_we     (w_load_acc),
      .i_waddr  (r_wptr),
      .i_wdata  (i_load_data),
      .i_re     (w_fetch_acc),
      .i_raddr  (w_idx[AW-1:0]),
      .o_rdata  (w_rdata),
      .o_loaded (w_loaded_bit)
   );

   // Halt is visible in the delivery cycle, then held by the sticky flag.
   assign w_halt_now  = r_instr_valid && !r_fault && (w_rdata[INSTR_W-1 -: OPC_W] == HALT_OPC);
   assign o_halted    = r_halted || w_halt_now;
   assign w_fetch_acc = i_fetch_req && !i_stall && o_ready && !o_halted && !i_load_start;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_instr_valid <= 1'b0;
         r_pc          <= '0;
         r_fault       <= 1'b0;
      end else if (i_load_start) begin
         r_instr_valid <= 1'b0;
      end else if (w_fetch_acc) begin
         r_instr_valid <= 1'b1;
         r_pc          <= i_fetch_pc;
         r_fault       <= !w_hit;
      end else if (!i_stall) begin
         r_instr_valid <= 1'b0;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)         r_halted <= 1'b0;
      else if (i_load_start) r_halted <= 1'b0;
      else if (w_halt_now)   r_halted <= 1'b1;
   end

   assign o_instr_valid = r_instr_valid;
   assign o_instr       = r_fault ? '0 : w_rdata;
   assign o_pc_out      = r_pc;
   assign o_fault       = r_fault;

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Self-checking bench for instr_mem_loadable: vector table for the fetch
// port, scoreboard of expected fetch results, and hand sequences for load/reset.
module tb_instr_mem_loadable;
   import cpu_isa_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
   logic [8:0]  load_data = '0;
   logic        load_ready;
   logic        fetch_req = 1'b0;
   logic [15:0] fetch_pc = '0;
   logic        stall = 1'b0;
   logic        instr_valid, fault, halted, ready;
   logic [8:0]  instr;
   logic [15:0] pc_out;

   always #5 clk = ~clk;

   instr_mem_loadable dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_load_start  (load_start),
      .i_load_valid  (load_valid),
      .i_load_last   (load_last),
      .i_load_data   (load_data),
      .o_load_ready  (load_ready),
      .i_fetch_req   (fetch_req),
      .i_fetch_pc    (fetch_pc),
      .i_stall       (stall),
      .o_instr_valid (instr_valid),
      .o_instr       (instr),
      .o_pc_out      (pc_out),
      .o_fault       (fault),
      .o_halted      (halted),
      .o_ready       (ready)
   );

   typedef struct {
      logic        req;
      logic [15:0] pc;
      logic        stl;
      logic        ev;
      logic [8:0]  ei;
      logic [15:0] ep;
      logic        ef;
      logic        eh;
   } vec_t;

   typedef struct {
      logic [15:0] pc;
      logic [8:0]  ins;
      logic        flt;
   } exp_t;

   vec_t       vt [15];
   exp_t       sbq [$];
   logic [8:0] prog [14];
   logic [8:0] m_mem [64];
   int         m_n = 0;
   bit         m_ready = 1'b0, m_halted = 1'b0;
   int         nchk = 0, nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input logic ls, input logic lv, input logic ll, input logic [8:0] ld,
                      input logic fr, input logic [15:0] fp, input logic st);
      @(negedge clk);
      load_start = ls; load_valid = lv; load_last = ll; load_data = ld;
      fetch_req = fr; fetch_pc = fp; stall = st;
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      cyc(1'b1, 1'b0, 1'b0, 9'h0, 1'b0, 16'd0, 1'b0);
      m_n = 0; m_ready = 1'b0; m_halted = 1'b0;
      sbq.delete();
   endtask

   task automatic load_word(input logic [8:0] d, input logic last);
      cyc(1'b0, 1'b1, last, d, 1'b0, 16'd0, 1'b0);
      m_mem[m_n] = d;
      m_n++;
      if (last || m_n == 64) m_ready = 1'b1;
   endtask

   task automatic fetch(input logic req, input logic [15:0] pc, input logic stl);
      bit   acc;
      int   idx;
      exp_t e;
      acc = req && !stl && m_ready && !m_halted;
      if (acc) begin
         idx   = int'(pc) - 1;
         e.pc  = pc;
         if (pc >= 16'd1 && idx < 64 && idx < m_n) begin
            e.ins = m_mem[idx]; e.flt = 1'b0;
         end else begin
            e.ins = 9'h0; e.flt = 1'b1;
         end
         sbq.push_back(e);
      end
      cyc(1'b0, 1'b0, 1'b0, 9'h0, req, pc, stl);
      if (acc) begin
         e = sbq.pop_front();
         chk("sb_valid", 32'(instr_valid), 32'd1);
         chk("sb_instr", 32'(instr), 32'(e.ins));
         chk("sb_pc",    32'(pc_out), 32'(e.pc));
         chk("sb_fault", 32'(fault), 32'(e.flt));
         if (!e.flt && e.ins[8:4] == OPC_HALT) m_halted = 1'b1;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, want $finish");
      $fatal(1);
   end

   initial begin
      prog = '{9'h061, 9'h120, 9'h062, 9'h001, 9'h0C7, 9'h013, 9'h0C2,
               9'h071, 9'h094, 9'h084, 9'h100, 9'h191, 9'h0A0, 9'h1A0};
      //         req pc      stl  ev  instr   pc_out  flt halt
      vt[0]  = '{1, 16'd1,  0,   1, 9'h061, 16'd1,  0,  0};
      vt[1]  = '{1, 16'd2,  0,   1, 9'h120, 16'd2,  0,  0};
      vt[2]  = '{1, 16'd0,  0,   1, 9'h000, 16'd0,  1,  0};
      vt[3]  = '{1, 16'd20, 0,   1, 9'h000, 16'd20, 1,  0};
      vt[4]  = '{1, 16'd70, 0,   1, 9'h000, 16'd70, 1,  0};
      vt[5]  = '{0, 16'd0,  0,   0, 9'h000, 16'd70, 1,  0};
      vt[6]  = '{1, 16'd5,  0,   1, 9'h0C7, 16'd5,  0,  0};
      vt[7]  = '{1, 16'd6,  1,   1, 9'h0C7, 16'd5,  0,  0};
      vt[8]  = '{1, 16'd6,  1,   1, 9'h0C7, 16'd5,  0,  0};
      vt[9]  = '{1, 16'd6,  1,   1, 9'h0C7, 16'd5,  0,  0};
      vt[10] = '{1, 16'd6,  0,   1, 9'h013, 16'd6,  0,  0};
      vt[11] = '{0, 16'd0,  0,   0, 9'h013, 16'd6,  0,  0};
      vt[12] = '{1, 16'd14, 0,   1, 9'h1A0, 16'd14, 0,  1};
      vt[13] = '{1, 16'd1,  0,   0, 9'h1A0, 16'd14, 0,  1};
      vt[14] = '{1, 16'd1,  1,   0, 9'h1A0, 16'd14, 0,  1};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid",      32'(instr_valid), 32'd0);
      chk("rst_instr",      32'(instr),       32'd0);
      chk("rst_pc",         32'(pc_out),      32'd0);
      chk("rst_fault",      32'(fault),       32'd0);
      chk("rst_halted",     32'(halted),      32'd0);
      chk("rst_load_ready", 32'(load_ready),  32'd0);
      chk("rst_ready",      32'(ready),       32'd0);
      @(negedge clk) rst_n = 1'b1;

      cyc(1'b0, 1'b0, 1'b0, 9'h0, 1'b1, 16'd1, 1'b0);
      chk("idle_fetch_ignored", 32'(instr_valid), 32'd0);

      start_load();
      chk("load_ready_after_start", 32'(load_ready), 32'd1);
      chk("not_ready_in_load",      32'(ready),      32'd0);
      for (int i = 0; i < 14; i++) begin
         if (i == 6) cyc(1'b0, 1'b0, 1'b0, 9'h1FF, 1'b1, 16'd1, 1'b0);
         load_word(prog[i], i == 13);
         if (i == 12) begin
            chk("ready_before_last", 32'(ready),       32'd0);
            chk("load_fetch_ignored", 32'(instr_valid), 32'd0);
         end
      end
      chk("ready_after_last",      32'(ready),      32'd1);
      chk("load_ready_after_last", 32'(load_ready), 32'd0);

      for (int i = 0; i < 15; i++) begin
         fetch(vt[i].req, vt[i].pc, vt[i].stl);
         chk($sformatf("vec%0d_valid", i),  32'(instr_valid), 32'(vt[i].ev));
         chk($sformatf("vec%0d_instr", i),  32'(instr),       32'(vt[i].ei));
         chk($sformatf("vec%0d_pc", i),     32'(pc_out),      32'(vt[i].ep));
         chk($sformatf("vec%0d_fault", i),  32'(fault),       32'(vt[i].ef));
         chk($sformatf("vec%0d_halted", i), 32'(halted),      32'(vt[i].eh));
      end

      // Restart while halted, with a competing fetch request.
      cyc(1'b1, 1'b0, 1'b0, 9'h0, 1'b1, 16'd1, 1'b0);
      m_n = 0; m_ready = 1'b0; m_halted = 1'b0;
      chk("restart_halted",     32'(halted),      32'd0);
      chk("restart_load_ready", 32'(load_ready),  32'd1);
      chk("restart_ready",      32'(ready),       32'd0);
      chk("restart_valid",      32'(instr_valid), 32'd0);

      // Asynchronous reset in the middle of a load.
      for (int i = 0; i < 3; i++) load_word(prog[i], 1'b0);
      chk("midload_load_ready", 32'(load_ready), 32'd1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_load_ready", 32'(load_ready), 32'd0);
      chk("async_instr",      32'(instr),      32'd0);
      chk("async_pc",         32'(pc_out),     32'd0);
      chk("async_ready",      32'(ready),      32'd0);
      m_n = 0; m_ready = 1'b0; m_halted = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 9'h0, 1'b1, 16'd1, 1'b0);
      chk("post_rst_fetch_ignored", 32'(instr_valid), 32'd0);

      // Restart inside LOAD drops the same-cycle word and rewinds the pointer.
      start_load();
      load_word(prog[5], 1'b0);
      load_word(prog[6], 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 9'h1FF, 1'b0, 16'd0, 1'b0);
      m_n = 0;
      chk("reload_in_load", 32'(load_ready), 32'd1);
      for (int i = 0; i < 3; i++) load_word(prog[i], i == 2);
      chk("short_prog_ready", 32'(ready), 32'd1);
      fetch(1'b1, 16'd1, 1'b0);
      fetch(1'b1, 16'd3, 1'b0);
      fetch(1'b1, 16'd4, 1'b0);
      chk("unloaded_after_reset_fault", 32'(fault), 32'd1);

      // Full-capacity load with no load_last: leaves LOAD at word DEPTH-1.
      start_load();
      for (int i = 0; i < 64; i++) begin
         load_word(9'(i * 5 + 3), 1'b0);
         if (i == 62) chk("cap_not_ready_63", 32'(ready), 32'd0);
      end
      chk("cap_ready_64",      32'(ready),      32'd1);
      chk("cap_load_ready_64", 32'(load_ready), 32'd0);
      fetch(1'b1, 16'd64, 1'b0);
      fetch(1'b1, 16'd65, 1'b0);
      fetch(1'b1, 16'd1,  1'b0);
      chk("cap_word0", 32'(instr), 32'h3);

      $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
      $finish;
   end

endmodule
